// File: rtl/vga_draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_draw_pkg
//  Description : Shared constants for the VGA drawing arbiter: screen size,
//                default field widths, arbiter state encoding and the
//                requester index of each drawing engine.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_draw_pkg;

  // Screen geometry
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Default field widths
  localparam int X_W_DEF   = 8;
  localparam int Y_W_DEF   = 7;
  localparam int COL_W_DEF = 3;

  // Arbiter state encoding
  localparam int          STATE_W = 2;
  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  ARB     = 2'd1;
  localparam logic [1:0]  BUSY    = 2'd2;
  localparam logic [1:0]  RELEASE = 2'd3;

  // Requester indices (0 = highest fixed priority)
  localparam int REQ_BACKGROUND = 0;
  localparam int REQ_CAR        = 1;
  localparam int REQ_NEW_SCENE  = 2;
  localparam int REQ_WIN        = 3;

endpackage : vga_draw_pkg
`default_nettype wire

// File: rtl/vga_draw_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : draw_arb_pick
//  Description : Combinational one-hot winner select. The search starts at the
//                requester just after i_ptr and wraps modulo NUM_REQ; feeding
//                i_ptr = NUM_REQ-1 gives plain lowest-index-wins priority.
//  Revision    : 1.0  initial release
// ============================================================================
module draw_arb_pick
  import vga_draw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  // Rotating scan: first set request after the pointer wins
  always_comb begin
    int   idx;
    logic found;
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(i_ptr) + 1 + k) % NUM_REQ;
      if (!found && i_req[idx[PTR_W-1:0]]) begin
        o_gnt[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule : draw_arb_pick
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_draw_arbiter
//  Description : Whole-job arbiter sharing the VGA adapter pixel-write port
//                among NUM_REQ drawing engines, with a per-job watchdog that
//                reclaims the port from a hung engine.
//                Optional macro DRAW_ARB_RR_EN selects round-robin arbitration
//                (default build: fixed priority, requester 0 highest).
//  Revision    : 1.0  initial release
// ============================================================================
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int X_W            = X_W_DEF,
  parameter int Y_W            = Y_W_DEF,
  parameter int COL_W          = COL_W_DEF,
  parameter int MAX_JOB_CYCLES = 19200
) (
  input  logic                     Clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       done_i,
  input  logic [NUM_REQ-1:0]       plot_i,
  input  logic [NUM_REQ*X_W-1:0]   x_i,
  input  logic [NUM_REQ*Y_W-1:0]   y_i,
  input  logic [NUM_REQ*COL_W-1:0] colour_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [X_W-1:0]           x_o,
  output logic [Y_W-1:0]           y_o,
  output logic [COL_W-1:0]         colour_o,
  output logic                     plot_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     timeout_sticky_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(MAX_JOB_CYCLES);
  localparam logic [WD_W-1:0] c_wd_limit = WD_W'(MAX_JOB_CYCLES - 1);

  logic [STATE_W-1:0] r_state;
  logic [WD_W-1:0]    r_wd;
  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_ptr;
  logic [X_W-1:0]     w_sel_x;
  logic [Y_W-1:0]     w_sel_y;
  logic [COL_W-1:0]   w_sel_col;
  logic               w_sel_plot;
  logic               w_sel_done;
  logic               w_sel_req;

`ifdef DRAW_ARB_RR_EN
  logic [PTR_W-1:0]   r_last_ptr;
  logic [PTR_W-1:0]   w_gnt_idx;

  // Binary index of the current owner, recorded as last winner on release
  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) w_gnt_idx = PTR_W'(k);
    end
  end

  assign w_ptr = r_last_ptr;
`else
  assign w_ptr = PTR_W'(NUM_REQ - 1);
`endif

  draw_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req (req_i),
    .i_ptr (w_ptr),
    .o_gnt (w_pick)
  );

  // AND-OR mux of the owner's signals; non-owners contribute nothing
  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_col  = '0;
    w_sel_plot = 1'b0;
    w_sel_done = 1'b0;
    w_sel_req  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sel_x    = w_sel_x   | (x_i[k*X_W +: X_W]           & {X_W{gnt_o[k]}});
      w_sel_y    = w_sel_y   | (y_i[k*Y_W +: Y_W]           & {Y_W{gnt_o[k]}});
      w_sel_col  = w_sel_col | (colour_i[k*COL_W +: COL_W]  & {COL_W{gnt_o[k]}});
      w_sel_plot = w_sel_plot | (plot_i[k] & gnt_o[k]);
      w_sel_done = w_sel_done | (done_i[k] & gnt_o[k]);
      w_sel_req  = w_sel_req  | (req_i[k]  & gnt_o[k]);
    end
  end

  // Arbiter state machine, watchdog and registered VGA outputs
  always_ff @(posedge Clock) begin
    if (!resetn) begin
      r_state          <= IDLE;
      r_wd             <= '0;
      gnt_o            <= '0;
      x_o              <= '0;
      y_o              <= '0;
      colour_o         <= '0;
      plot_o           <= 1'b0;
      busy_o           <= 1'b0;
      timeout_o        <= 1'b0;
      timeout_sticky_o <= 1'b0;
`ifdef DRAW_ARB_RR_EN
      r_last_ptr       <= PTR_W'(NUM_REQ - 1);
`endif
    end else begin
      timeout_o <= 1'b0;
      plot_o    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_state <= ARB;
            busy_o  <= 1'b1;
          end
        end

        ARB: begin
          if (|req_i) begin
            gnt_o   <= w_pick;
            r_wd    <= '0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        BUSY: begin
          // Owner's pixel is registered every busy cycle, including the last
          x_o      <= w_sel_x;
          y_o      <= w_sel_y;
          colour_o <= w_sel_col;
          plot_o   <= w_sel_plot;
          if (r_wd != '1) r_wd <= r_wd + 1'b1;
          // Done takes precedence over abort and watchdog expiry
          if (w_sel_done || !w_sel_req || (r_wd == c_wd_limit)) begin
            r_state <= RELEASE;
            gnt_o   <= '0;
`ifdef DRAW_ARB_RR_EN
            r_last_ptr <= w_gnt_idx;
`endif
            if (!w_sel_done && w_sel_req) begin
              timeout_o        <= 1'b1;
              timeout_sticky_o <= 1'b1;
            end
          end
        end

        RELEASE: begin
          if (|req_i) begin
            r_state <= ARB;
          end else begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          gnt_o   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule : vga_draw_arbiter
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_draw_arbiter
//  Description : Directed self-checking bench for vga_draw_arbiter
//                (watchdog limit shortened to 16 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_draw_arbiter;

  localparam int NUM_REQ = 4;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COL_W   = 3;

  logic                     Clock;
  logic                     resetn;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ-1:0]       done_i;
  logic [NUM_REQ-1:0]       plot_i;
  logic [NUM_REQ*X_W-1:0]   x_i;
  logic [NUM_REQ*Y_W-1:0]   y_i;
  logic [NUM_REQ*COL_W-1:0] colour_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [X_W-1:0]           x_o;
  logic [Y_W-1:0]           y_o;
  logic [COL_W-1:0]         colour_o;
  logic                     plot_o;
  logic                     busy_o;
  logic                     timeout_o;
  logic                     timeout_sticky_o;

  int r_checks;
  int r_errors;

  vga_draw_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .X_W            (X_W),
    .Y_W            (Y_W),
    .COL_W          (COL_W),
    .MAX_JOB_CYCLES (16)
  ) dut (
    .Clock            (Clock),
    .resetn           (resetn),
    .req_i            (req_i),
    .done_i           (done_i),
    .plot_i           (plot_i),
    .x_i              (x_i),
    .y_i              (y_i),
    .colour_i         (colour_i),
    .gnt_o            (gnt_o),
    .x_o              (x_o),
    .y_o              (y_o),
    .colour_o         (colour_o),
    .plot_o           (plot_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .timeout_sticky_o (timeout_sticky_o)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_engine(input int k, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input logic p);
    x_i[k*X_W +: X_W]          = x;
    y_i[k*Y_W +: Y_W]          = y;
    colour_i[k*COL_W +: COL_W] = c;
    plot_i[k]                  = p;
  endtask

  logic [NUM_REQ-1:0] exp_gnt [3];

  initial begin
    r_checks = 0;
    r_errors = 0;
    resetn   = 1'b0;
    req_i    = '0;
    done_i   = '0;
    plot_i   = '0;
    x_i      = '0;
    y_i      = '0;
    colour_i = '0;

    // Reset state
    tick(); tick();
    check("rst_gnt", 32'(gnt_o), 0);
    check("rst_plot", 32'(plot_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_x", 32'(x_o), 0);
    check("rst_sticky", 32'(timeout_sticky_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    resetn = 1'b1;
    tick();

    // Single job on engine 0
    req_i = 4'b0001;
    set_engine(0, 8'd5, 7'd7, 3'd3, 1'b1);
    tick();
    check("s_arb_busy", 32'(busy_o), 1);
    check("s_arb_gnt", 32'(gnt_o), 0);
    tick();
    check("s_gnt", 32'(gnt_o), 32'b0001);
    check("s_plot_lat", 32'(plot_o), 0);
    tick();
    check("s_x", 32'(x_o), 5);
    check("s_y", 32'(y_o), 7);
    check("s_col", 32'(colour_o), 3);
    check("s_plot", 32'(plot_o), 1);
    plot_i[0] = 1'b0; done_i[0] = 1'b1; req_i = 4'b0000;
    tick();
    check("s_rel_gnt", 32'(gnt_o), 0);
    check("s_rel_plot", 32'(plot_o), 0);
    check("s_rel_busy", 32'(busy_o), 1);
    done_i = '0;
    tick();
    check("s_idle_busy", 32'(busy_o), 0);

    // Contention 1 vs 3, engine 3 plots while engine 1 owns the port
    req_i = 4'b1010;
    set_engine(1, 8'd10, 7'd20, 3'd1, 1'b1);
    set_engine(3, 8'd99, 7'd99, 3'd7, 1'b1);
    tick(); tick();
    check("c_gnt1", 32'(gnt_o), 32'b0010);
    tick();
    check("c_x1", 32'(x_o), 10);
    check("c_y1", 32'(y_o), 20);
    check("c_col1", 32'(colour_o), 1);
    check("c_plot1", 32'(plot_o), 1);
    plot_i[1] = 1'b0;
    tick();
    check("c_ignore_plot", 32'(plot_o), 0);
    check("c_ignore_x", 32'(x_o), 10);
    // Final pixel together with done
    set_engine(1, 8'd11, 7'd21, 3'd2, 1'b1);
    done_i[1] = 1'b1; req_i = 4'b1000;
    tick();
    check("c_rel_gnt", 32'(gnt_o), 0);
    check("c_last_plot", 32'(plot_o), 1);
    check("c_last_x", 32'(x_o), 11);
    done_i = '0; plot_i[1] = 1'b0;
    tick();
    check("c_dead_plot", 32'(plot_o), 0);
    check("c_dead_gnt", 32'(gnt_o), 0);
    tick();
    check("c_gnt3", 32'(gnt_o), 32'b1000);
    tick();
    check("c_x3", 32'(x_o), 99);
    check("c_plot3", 32'(plot_o), 1);
    plot_i = '0; done_i[3] = 1'b1; req_i = '0;
    tick();
    done_i = '0;
    tick();
    check("c_idle_busy", 32'(busy_o), 0);

    // Watchdog on engine 2 (never signals done)
    req_i = 4'b0100;
    tick(); tick();
    check("w_gnt", 32'(gnt_o), 32'b0100);
    for (int i = 0; i < 15; i++) begin
      check("w_no_timeout", 32'(timeout_o), 0);
      tick();
    end
    check("w_hold_gnt", 32'(gnt_o), 32'b0100);
    check("w_pre_timeout", 32'(timeout_o), 0);
    tick();
    check("w_timeout", 32'(timeout_o), 1);
    check("w_sticky", 32'(timeout_sticky_o), 1);
    check("w_rel_gnt", 32'(gnt_o), 0);
    req_i = '0;
    tick();
    check("w_pulse_end", 32'(timeout_o), 0);
    check("w_sticky_hold", 32'(timeout_sticky_o), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("w_sticky_clr", 32'(timeout_sticky_o), 0);
    check("w_gnt_clr", 32'(gnt_o), 0);
    tick();

    // Abort: engine 1 drops its request mid-job
    req_i = 4'b0010;
    set_engine(1, 8'd1, 7'd1, 3'd1, 1'b1);
    tick(); tick();
    check("a_gnt", 32'(gnt_o), 32'b0010);
    tick();
    req_i = '0; plot_i = '0;
    tick();
    check("a_rel_gnt", 32'(gnt_o), 0);
    check("a_rel_busy", 32'(busy_o), 1);
    tick();
    check("a_idle_busy", 32'(busy_o), 0);

    // Reset mid-job
    req_i = 4'b0001;
    set_engine(0, 8'd3, 7'd4, 3'd5, 1'b1);
    tick(); tick(); tick();
    check("r_plot_pre", 32'(plot_o), 1);
    resetn = 1'b0;
    tick();
    check("r_gnt", 32'(gnt_o), 0);
    check("r_plot", 32'(plot_o), 0);
    check("r_busy", 32'(busy_o), 0);
    check("r_x", 32'(x_o), 0);
    resetn = 1'b1; req_i = '0; plot_i = '0;
    tick();
    check("r_idle_busy", 32'(busy_o), 0);

    // Repeated jobs with engines 0 and 1 both requesting
`ifdef DRAW_ARB_RR_EN
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0001;
`else
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b0001;
`endif
    req_i = 4'b0011;
    tick(); tick();
    for (int j = 0; j < 3; j++) begin
      check("rr_gnt", 32'(gnt_o), 32'(exp_gnt[j]));
      done_i = exp_gnt[j];
      tick();
      done_i = '0;
      tick(); tick();
    end
    req_i = '0;
    tick(); tick(); tick();
    check("rr_idle_busy", 32'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule : tb_vga_draw_arbiter
`default_nettype wire

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) among NUM_REQ drawing engines: background, car, new-background/new-car and win screen.
- Grants are whole-job: once an engine is granted, it owns the port until it signals job done.
- Sits between the drawing datapaths and the VGA adapter. The game controller only raises per-engine requests and waits for done.
- Includes a watchdog that reclaims the port from a hung engine.

Parameters:
- NUM_REQ, 4, number of drawing engines (requester 0 = highest fixed priority)
- X_W, 8, x coordinate width (160-column screen)
- Y_W, 7, y coordinate width (120-row screen)
- COL_W, 3, colour width
- MAX_JOB_CYCLES, 19200, watchdog limit in cycles for one granted job (one full screen)

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- resetn  in  1  synchronous active-low reset, sampled on rising edge of Clock
- req_i  in  NUM_REQ  per-engine request; held high for the whole job
- done_i  in  NUM_REQ  per-engine job-done; valid only from the granted engine
- plot_i  in  NUM_REQ  per-engine pixel-write strobe
- x_i  in  NUM_REQ*X_W  packed x coordinates, engine k at slice k
- y_i  in  NUM_REQ*Y_W  packed y coordinates
- colour_i  in  NUM_REQ*COL_W  packed colours
- gnt_o  out  NUM_REQ  one-hot grant; all-zero when no owner
- x_o  out  X_W  registered x to VGA adapter
- y_o  out  Y_W  registered y to VGA adapter
- colour_o  out  COL_W  registered colour to VGA adapter
- plot_o  out  1  registered write enable to VGA adapter
- busy_o  out  1  high while in ARB, BUSY or RELEASE
- timeout_o  out  1  one-cycle pulse when the watchdog reclaims the port
- timeout_sticky_o  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (resetn=0 at a rising edge): state=IDLE; gnt_o, x_o, y_o, colour_o, plot_o, busy_o, timeout_o, timeout_sticky_o all 0; watchdog counter 0.
- Reset mid-job drops the grant on the same edge. No pixel is written on the following cycle.
- State machine:
  - IDLE: if any req_i bit is set, go to ARB; otherwise stay in IDLE.
  - ARB: one cycle. Pick a winner (lowest index set in req_i), latch its one-hot into gnt_o, clear the watchdog, go to BUSY. If req_i is all zero by this cycle, return to IDLE with no grant.
  - BUSY: the granted engine's plot/x/y/colour are registered to the outputs, giving 1-cycle latency from engine inputs to VGA outputs.
    - done_i[g]=1 → RELEASE.
    - req_i[g]=0 without done (abort) → RELEASE.
    - Watchdog reaches MAX_JOB_CYCLES-1 → RELEASE, pulse timeout_o, set timeout_sticky_o.
  - RELEASE: one cycle. gnt_o=0 and plot_o=0, which guarantees a dead cycle between owners. Go to ARB if any req_i is set, else IDLE.
- Non-granted engines' plot_i, done_i and coordinates are ignored. plot_o is 0 in every state except BUSY.
- If done_i[g] and plot_i[g] are high in the same cycle, that final pixel is still registered and written.
- When done and watchdog expiry coincide, done wins: no timeout pulse.
- Watchdog counter is $clog2(MAX_JOB_CYCLES) bits wide, saturating. It increments every BUSY cycle.
- Requests arriving during BUSY are held off until RELEASE. The arbiter never pre-empts an owner.

Optional Feature:
- Macro: DRAW_ARB_RR_EN
- Defined: round-robin arbitration. A last-winner pointer is updated at each RELEASE. Search starts at last_winner+1 and wraps modulo NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 wins first after reset.
- Undefined: fixed priority, lowest index wins, no pointer register.

Decomposition:
- Shared package vga_draw_pkg holds:
  - screen constants (SCREEN_W=160, SCREEN_H=120)
  - X_W/Y_W/COL_W defaults
  - state encoding localparams (IDLE, ARB, BUSY, RELEASE)
  - requester index constants (REQ_BACKGROUND=0, REQ_CAR=1, REQ_NEW_SCENE=2, REQ_WIN=3)
- One natural sub-module: draw_arb_pick, a combinational one-hot winner select. It takes the request vector and an optional round-robin pointer and returns the one-hot grant.

Test Plan:
- Single job: req_i=0001, engine 0 plots x=5, y=7, colour=3 → after grant, x_o=5, y_o=7, colour_o=3, plot_o=1 one cycle later. done → RELEASE → IDLE, gnt_o=0000.
- Contention: req_i=1010 together → gnt_o=0010 first. After done and one dead cycle with plot_o=0, gnt_o=1000.
- Ignore non-owner: engine 3 drives plot_i[3]=1 while engine 1 holds the grant → plot_o follows engine 1 only, and engine 3 coordinates never appear.
- Watchdog: MAX_JOB_CYCLES=16, engine 2 never raises done → timeout_o pulses exactly once after 16 BUSY cycles. timeout_sticky_o=1 until reset, then gnt_o returns to 0000.
- Abort and reset: req_i[1] drops mid-job → RELEASE next cycle. resetn=0 mid-job → all outputs 0 on the following cycle, and state is IDLE.
- DRAW_ARB_RR_EN: req_i=0011 held with repeated jobs → grants alternate 0001, 0010, 0001. Without the macro, every grant is 0001.
